// File: rtl/display_mode_ctrl.sv
// Display-mode controller: picks one of NUM_SRC BCD sources for the display,
// with idle auto-return to source 0 and a blinking edit cursor on source 0.
module display_mode_ctrl #(
    parameter int          DIGITS     = 8,
    parameter int          NUM_SRC    = 4,
    parameter int          IDLE_CYC   = 10000,
    parameter int          BLINK_CYC  = 250,
    parameter logic [3:0]  BLANK_CODE = 4'hF,
    parameter int          SW         = $clog2(NUM_SRC),
    parameter int          CW         = $clog2(DIGITS)
) (
    input  logic                          CLK1K,
    input  logic                          RST,
    input  logic [NUM_SRC*DIGITS*4-1:0]   SRC_DATA,
    input  logic                          MODE_KEY,
    input  logic                          EDIT_KEY,
    input  logic                          NEXT_KEY,
    output logic [DIGITS*4-1:0]           DISP_DATA,
    output logic [SW-1:0]                 SEL_SRC,
    output logic [CW-1:0]                 CURSOR,
    output logic                          EDIT_ACTIVE,
    output logic                          MODE_CHG
);

    localparam int IW = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    localparam logic [SW-1:0] SRC_LAST   = SW'(NUM_SRC - 1);
    localparam logic [CW-1:0] CUR_LAST   = CW'(DIGITS - 1);
    localparam logic [IW-1:0] IDLE_FIRE  = IW'((IDLE_CYC > 0) ? IDLE_CYC - 1 : 0);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    typedef enum logic {VIEW, EDIT} state_t;

    state_t               state;
    state_t               state_next;
    logic [IW-1:0]        idle_cnt;
    logic [BW-1:0]        blink_cnt;
    logic                 blink_on;
    logic                 any_key;
    logic                 timeout;
    logic [SW-1:0]        sel_next;
    logic [CW-1:0]        cursor_next;
    logic [DIGITS*4-1:0]  disp_next;

    // Only the highest-priority asserted key is considered; a timeout can
    // only act in a cycle with no key at all.
    always_comb begin
        any_key     = MODE_KEY | EDIT_KEY | NEXT_KEY;
        timeout     = (IDLE_CYC != 0) && !any_key && (idle_cnt == IDLE_FIRE);
        state_next  = state;
        sel_next    = SEL_SRC;
        cursor_next = CURSOR;
        if (EDIT_KEY) begin
            if (state == EDIT) begin
                state_next = VIEW;
            end else if (SEL_SRC == '0) begin
                state_next  = EDIT;
                cursor_next = '0;
            end
        end else if (MODE_KEY) begin
            if (state == VIEW)
                sel_next = (SEL_SRC == SRC_LAST) ? '0 : SEL_SRC + SW'(1);
        end else if (NEXT_KEY) begin
            if (state == EDIT)
                cursor_next = (CURSOR == CUR_LAST) ? '0 : CURSOR + CW'(1);
        end else if (timeout) begin
            if (state == EDIT)
                state_next = VIEW;
            else
                sel_next = '0;
        end
    end

    always_comb begin
        disp_next = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (state == EDIT && !blink_on && CURSOR == CW'(d))
                disp_next[d*4 +: 4] = BLANK_CODE;
            else
                disp_next[d*4 +: 4] = SRC_DATA[(SEL_SRC * DIGITS + d) * 4 +: 4];
        end
    end

    always_ff @(posedge CLK1K) begin
        if (RST) begin
            state       <= VIEW;
            SEL_SRC     <= '0;
            CURSOR      <= '0;
            EDIT_ACTIVE <= 1'b0;
            MODE_CHG    <= 1'b0;
            DISP_DATA   <= '0;
            blink_on    <= 1'b1;
            blink_cnt   <= '0;
            idle_cnt    <= '0;
        end else begin
            state       <= state_next;
            SEL_SRC     <= sel_next;
            CURSOR      <= cursor_next;
            EDIT_ACTIVE <= (state_next == EDIT);
            MODE_CHG    <= (sel_next != SEL_SRC);
            DISP_DATA   <= disp_next;

            if (any_key || timeout)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX)
                idle_cnt <= idle_cnt + IW'(1);

            // Blink runs only while staying in EDIT; entry and exit restart it.
            if (state == EDIT && state_next == EDIT) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= !blink_on;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end else begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Self-checking bench for display_mode_ctrl: behavioural reference model feeds a
// scoreboard queue, plus directed checks of the key sequences and timing corners.
module tb_display_mode_ctrl;

    localparam int DIGITS    = 8;
    localparam int NUM_SRC   = 4;
    localparam int IDLE_CYC  = 20;
    localparam int BLINK_CYC = 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_SRC*DIGITS*4-1:0] src;
    logic                        mode_key = 1'b0;
    logic                        edit_key = 1'b0;
    logic                        next_key = 1'b0;
    logic [DIGITS*4-1:0]         disp_data;
    logic [1:0]                  sel_src;
    logic [2:0]                  cursor;
    logic                        edit_active;
    logic                        mode_chg;

    display_mode_ctrl #(
        .DIGITS    (DIGITS),
        .NUM_SRC   (NUM_SRC),
        .IDLE_CYC  (IDLE_CYC),
        .BLINK_CYC (BLINK_CYC),
        .BLANK_CODE(4'hF)
    ) dut (
        .CLK1K      (clk),
        .RST        (rst),
        .SRC_DATA   (src),
        .MODE_KEY   (mode_key),
        .EDIT_KEY   (edit_key),
        .NEXT_KEY   (next_key),
        .DISP_DATA  (disp_data),
        .SEL_SRC    (sel_src),
        .CURSOR     (cursor),
        .EDIT_ACTIVE(edit_active),
        .MODE_CHG   (mode_chg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    typedef struct {
        bit          edit;
        int          sel;
        int          cur;
        bit          chg;
        logic [31:0] disp;
    } exp_t;

    exp_t q[$];

    bit          m_edit = 0;
    bit          m_on   = 1;
    int          m_sel  = 0;
    int          m_cur  = 0;
    int          m_idle = 0;
    int          m_bcnt = 0;
    logic [31:0] m_disp = '0;

    // Reference model: behaviour written straight from the key/timeout rules.
    always @(posedge clk) begin
        exp_t        e;
        logic [31:0] nd;
        bit          was_edit;
        int          old_sel;
        was_edit = m_edit;
        old_sel  = m_sel;
        if (rst) begin
            m_edit = 0; m_on = 1; m_sel = 0; m_cur = 0;
            m_idle = 0; m_bcnt = 0; m_disp = '0;
            e.chg  = 0;
        end else begin
            for (int d = 0; d < DIGITS; d++)
                nd[d*4 +: 4] = (m_edit && !m_on && d == m_cur) ? 4'hF
                                                              : src[(m_sel*DIGITS + d)*4 +: 4];
            m_disp = nd;
            if (edit_key || mode_key || next_key) begin
                m_idle = 0;
                if (edit_key) begin
                    if (m_edit) m_edit = 0;
                    else if (m_sel == 0) begin m_edit = 1; m_cur = 0; end
                end else if (mode_key) begin
                    if (!m_edit) m_sel = (m_sel + 1) % NUM_SRC;
                end else if (m_edit) begin
                    m_cur = (m_cur + 1) % DIGITS;
                end
            end else if (m_idle == IDLE_CYC - 1) begin
                m_idle = 0;
                if (m_edit) m_edit = 0;
                else m_sel = 0;
            end else if (m_idle < IDLE_CYC) begin
                m_idle++;
            end
            if (was_edit && m_edit) begin
                m_bcnt++;
                if (m_bcnt == BLINK_CYC) begin m_bcnt = 0; m_on = !m_on; end
            end else begin
                m_bcnt = 0; m_on = 1;
            end
            e.chg = (m_sel != old_sel);
        end
        e.edit = m_edit;
        e.sel  = m_sel;
        e.cur  = m_cur;
        e.disp = m_disp;
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("sb_sel",      32'(sel_src),     e.sel);
            check("sb_edit",     32'(edit_active), 32'(e.edit));
            check("sb_cursor",   32'(cursor),      e.cur);
            check("sb_mode_chg", 32'(mode_chg),    32'(e.chg));
            check("sb_disp",     disp_data,        e.disp);
        end
    end

    task automatic pulse(input bit m, input bit ed, input bit n);
        mode_key = m; edit_key = ed; next_key = n;
        @(negedge clk);
        mode_key = 0; edit_key = 0; next_key = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int s = 0; s < NUM_SRC; s++)
            for (int d = 0; d < DIGITS; d++)
                src[(s*DIGITS + d)*4 +: 4] = 4'((s*5 + d + 7) % 16);

        wait_cyc(3);
        rst = 0;
        check("rst_sel",  32'(sel_src),     0);
        check("rst_edit", 32'(edit_active), 0);
        check("rst_disp", disp_data,        0);

        // Mode cycling with one MODE_CHG pulse per change
        for (int i = 1; i <= 4; i++) begin
            pulse(1, 0, 0);
            check("mode_sel", 32'(sel_src), i % NUM_SRC);
            check("mode_chg_hi", 32'(mode_chg), 1);
            wait_cyc(1);
            check("mode_chg_lo", 32'(mode_chg), 0);
            wait_cyc(3);
        end

        // Idle timeout returns to source 0 exactly IDLE_CYC cycles after the last key
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        wait_cyc(IDLE_CYC - 1);
        check("idle_before", 32'(sel_src), 2);
        wait_cyc(1);
        check("idle_fire", 32'(sel_src), 0);
        check("idle_chg",  32'(mode_chg), 1);

        // A key one cycle before the timeout restarts the count
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        wait_cyc(IDLE_CYC - 2);
        pulse(0, 0, 1);
        check("restart_sel", 32'(sel_src), 2);
        wait_cyc(IDLE_CYC - 1);
        check("restart_hold", 32'(sel_src), 2);
        wait_cyc(1);
        check("restart_fire", 32'(sel_src), 0);

        // Edit entry only from source 0
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check("edit_ignored", 32'(edit_active), 0);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        check("back_to_0", 32'(sel_src), 0);
        pulse(0, 1, 0);
        check("edit_enter",  32'(edit_active), 1);
        check("edit_cursor", 32'(cursor), 0);

        // Digit 0 blinks 4 on / 4 off, other digits steady
        for (int k = 1; k <= 12; k++) begin
            wait_cyc(1);
            check("blink_d0", 32'(disp_data[3:0]), (k >= 5 && k <= 8) ? 32'hF : 32'h7);
            check("blink_d1", 32'(disp_data[7:4]), 32'h8);
        end

        for (int i = 1; i <= DIGITS; i++) begin
            pulse(0, 0, 1);
            check("cursor_step", 32'(cursor), i % DIGITS);
        end
        pulse(1, 1, 0);
        check("combo_edit", 32'(edit_active), 0);
        check("combo_sel",  32'(sel_src), 0);

        // Reset while a non-zero cursor digit is blanked
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        pulse(0, 0, 1);
        wait_cyc(3);
        check("pre_rst_blank", 32'(disp_data[11:8]), 32'hF);
        rst = 1;
        wait_cyc(1);
        rst = 0;
        check("rst_edit2",   32'(edit_active), 0);
        check("rst_cursor2", 32'(cursor), 0);
        check("rst_sel2",    32'(sel_src), 0);
        check("rst_disp2",   disp_data, 0);

        // Random key traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            mode_key = ($urandom_range(0, 11) == 0);
            edit_key = ($urandom_range(0, 13) == 0);
            next_key = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0)
                src = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        mode_key = 0; edit_key = 0; next_key = 0; rst = 0;
        wait_cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
